// File: rtl/dmem_arb_pkg.sv
// rtl/dmem_arb_pkg.sv - shared types for the data-memory port arbiter
package dmem_arb_pkg;

    typedef enum logic {
        OWNER_PROC = 1'b0,
        OWNER_EXT  = 1'b1
    } owner_t;

    typedef struct packed {
        logic   valid;
        owner_t owner;
        logic   is_read;
    } inflight_t;

    localparam int MEM_LAT_MAX = 4;

endpackage

// File: rtl/dmem_arb_rr.sv
// rtl/dmem_arb_rr.sv - 2-way round-robin grant with priority pointer
module dmem_arb_rr
    import dmem_arb_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic proc_val_i,
    input  logic ext_val_i,
    output logic proc_gnt_o,
    output logic ext_gnt_o
);

    owner_t prio_q, prio_d;

    // Grants are forced low during reset so no handshake can fire in that cycle
    always_comb begin
        proc_gnt_o = 1'b0;
        ext_gnt_o  = 1'b0;
        if (rst) begin
            if (proc_val_i && (!ext_val_i || prio_q == OWNER_PROC)) begin
                proc_gnt_o = 1'b1;
            end else if (ext_val_i) begin
                ext_gnt_o = 1'b1;
            end
        end
    end

    always_comb begin
        prio_d = prio_q;
        if (proc_gnt_o) begin
            prio_d = OWNER_EXT;
        end else if (ext_gnt_o) begin
            prio_d = OWNER_PROC;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            prio_q <= OWNER_PROC;
        end else begin
            prio_q <= prio_d;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - shares the data-memory port between PROC and EXT requesters
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int MEM_LAT = 1,
    parameter int AW      = 32,
    parameter int DW      = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          proc_req_val,
    output logic          proc_req_rdy,
    input  logic          proc_req_type,
    input  logic [AW-1:0] proc_req_addr,
    input  logic [DW-1:0] proc_req_wdata,
    output logic          proc_resp_val,
    output logic [DW-1:0] proc_resp_rdata,
    input  logic          ext_req_val,
    output logic          ext_req_rdy,
    input  logic          ext_req_type,
    input  logic [AW-1:0] ext_req_addr,
    input  logic [DW-1:0] ext_req_wdata,
    output logic          ext_resp_val,
    output logic [DW-1:0] ext_resp_rdata,
    output logic          memreq_val,
    output logic          memreq_type,
    output logic [AW-1:0] memreq_addr,
    output logic [DW-1:0] memreq_wdata,
    input  logic [DW-1:0] memresp_rdata,
    output logic          arb_owner
);

    localparam int LAT_DEPTH = (MEM_LAT > MEM_LAT_MAX) ? MEM_LAT_MAX : MEM_LAT;

    logic      proc_gnt, ext_gnt;
    inflight_t stage0_d;
    inflight_t pipe_q [LAT_DEPTH];
    inflight_t head;
    logic      resp_fire;

    dmem_arb_rr u_rr (
        .clk        (clk),
        .rst        (rst),
        .proc_val_i (proc_req_val),
        .ext_val_i  (ext_req_val),
        .proc_gnt_o (proc_gnt),
        .ext_gnt_o  (ext_gnt)
    );

    assign proc_req_rdy = proc_gnt;
    assign ext_req_rdy  = ext_gnt;
    assign arb_owner    = ext_gnt;

    always_comb begin
        memreq_val   = proc_gnt | ext_gnt;
        memreq_type  = 1'b0;
        memreq_addr  = '0;
        memreq_wdata = '0;
        if (proc_gnt) begin
            memreq_type  = proc_req_type;
            memreq_addr  = proc_req_addr;
            memreq_wdata = proc_req_wdata;
        end else if (ext_gnt) begin
            memreq_type  = ext_req_type;
            memreq_addr  = ext_req_addr;
            memreq_wdata = ext_req_wdata;
        end
    end

    always_comb begin
        stage0_d.valid   = memreq_val;
        stage0_d.owner   = ext_gnt ? OWNER_EXT : OWNER_PROC;
        stage0_d.is_read = memreq_val & ~memreq_type;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < LAT_DEPTH; i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            pipe_q[0] <= stage0_d;
            for (int i = 1; i < LAT_DEPTH; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

    // Gating with rst drops a response that would otherwise land in the reset cycle
    assign head      = pipe_q[LAT_DEPTH-1];
    assign resp_fire = head.valid & rst;

    always_comb begin
        proc_resp_val   = resp_fire && (head.owner == OWNER_PROC);
        ext_resp_val    = resp_fire && (head.owner == OWNER_EXT);
        proc_resp_rdata = (proc_resp_val && head.is_read) ? memresp_rdata : '0;
        ext_resp_rdata  = (ext_resp_val && head.is_read) ? memresp_rdata : '0;
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - self-checking bench running MEM_LAT=1,2,3 instances in lockstep
module tb_dmem_arbiter;

    typedef struct packed {
        logic        owner;
        logic [31:0] data;
        int          due;
    } exp_t;

    logic clk;
    logic rst;
    logic proc_req_val, proc_req_type, ext_req_val, ext_req_type;
    logic [31:0] proc_req_addr, proc_req_wdata, ext_req_addr, ext_req_wdata;

    logic [2:0]       p_rdy, e_rdy, p_rv, e_rv, m_val, m_type, own;
    logic [2:0][31:0] p_rd, e_rd, m_addr, m_wd, m_rd;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc     = 0;
    logic        prio;
    logic [31:0] ref_mem [256];
    exp_t        sb [3][$];

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int L = g + 1;
        logic [31:0] mem [256];
        logic [31:0] rd_pipe [L];

        dmem_arbiter #(.MEM_LAT(L), .AW(32), .DW(32)) u_dut (
            .clk             (clk),
            .rst             (rst),
            .proc_req_val    (proc_req_val),
            .proc_req_rdy    (p_rdy[g]),
            .proc_req_type   (proc_req_type),
            .proc_req_addr   (proc_req_addr),
            .proc_req_wdata  (proc_req_wdata),
            .proc_resp_val   (p_rv[g]),
            .proc_resp_rdata (p_rd[g]),
            .ext_req_val     (ext_req_val),
            .ext_req_rdy     (e_rdy[g]),
            .ext_req_type    (ext_req_type),
            .ext_req_addr    (ext_req_addr),
            .ext_req_wdata   (ext_req_wdata),
            .ext_resp_val    (e_rv[g]),
            .ext_resp_rdata  (e_rd[g]),
            .memreq_val      (m_val[g]),
            .memreq_type     (m_type[g]),
            .memreq_addr     (m_addr[g]),
            .memreq_wdata    (m_wd[g]),
            .memresp_rdata   (m_rd[g]),
            .arb_owner       (own[g])
        );

        always @(posedge clk) begin
            if (m_val[g] && m_type[g]) mem[m_addr[g][9:2]] <= m_wd[g];
            rd_pipe[0] <= mem[m_addr[g][9:2]];
            for (int k = 1; k < L; k++) rd_pipe[k] <= rd_pipe[k-1];
        end
        assign m_rd[g] = rd_pipe[L-1];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic r,
                        input logic pv, input logic pt, input logic [31:0] pa, input logic [31:0] pd,
                        input logic ev, input logic et, input logic [31:0] ea, input logic [31:0] ed);
        logic        gp, ge, gt;
        logic [31:0] ga, gd;
        exp_t        e;
        @(posedge clk);
        #1;
        rst = r;
        proc_req_val = pv; proc_req_type = pt; proc_req_addr = pa; proc_req_wdata = pd;
        ext_req_val  = ev; ext_req_type  = et; ext_req_addr  = ea; ext_req_wdata  = ed;
        @(negedge clk);
        gp = r && pv && (!ev || prio == 1'b0);
        ge = r && ev && !gp;
        gt = gp ? pt : (ge ? et : 1'b0);
        ga = gp ? pa : (ge ? ea : 32'h0);
        gd = gp ? pd : (ge ? ed : 32'h0);
        if (!r) for (int i = 0; i < 3; i++) sb[i].delete();
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("L%0d@%0d proc_req_rdy", i+1, cyc), {31'b0, p_rdy[i]}, {31'b0, gp});
            chk($sformatf("L%0d@%0d ext_req_rdy", i+1, cyc), {31'b0, e_rdy[i]}, {31'b0, ge});
            chk($sformatf("L%0d@%0d memreq_val", i+1, cyc), {31'b0, m_val[i]}, {31'b0, gp | ge});
            chk($sformatf("L%0d@%0d arb_owner", i+1, cyc), {31'b0, own[i]}, {31'b0, ge});
            chk($sformatf("L%0d@%0d memreq_type", i+1, cyc), {31'b0, m_type[i]}, {31'b0, gt});
            chk($sformatf("L%0d@%0d memreq_addr", i+1, cyc), m_addr[i], ga);
            chk($sformatf("L%0d@%0d memreq_wdata", i+1, cyc), m_wd[i], gd);
            if (sb[i].size() > 0 && sb[i][0].due == cyc) begin
                e = sb[i].pop_front();
                chk($sformatf("L%0d@%0d proc_resp_val", i+1, cyc), {31'b0, p_rv[i]}, {31'b0, !e.owner});
                chk($sformatf("L%0d@%0d ext_resp_val", i+1, cyc), {31'b0, e_rv[i]}, {31'b0, e.owner});
                chk($sformatf("L%0d@%0d proc_resp_rdata", i+1, cyc), p_rd[i], e.owner ? 32'h0 : e.data);
                chk($sformatf("L%0d@%0d ext_resp_rdata", i+1, cyc), e_rd[i], e.owner ? e.data : 32'h0);
            end else begin
                chk($sformatf("L%0d@%0d proc_resp_val idle", i+1, cyc), {31'b0, p_rv[i]}, 32'h0);
                chk($sformatf("L%0d@%0d ext_resp_val idle", i+1, cyc), {31'b0, e_rv[i]}, 32'h0);
            end
        end
        if (gp || ge) begin
            if (gt) ref_mem[ga[9:2]] = gd;
            e.owner = ge;
            e.data  = gt ? 32'h0 : ref_mem[ga[9:2]];
            for (int i = 0; i < 3; i++) begin
                e.due = cyc + i + 1;
                sb[i].push_back(e);
            end
            prio = gp ? 1'b1 : 1'b0;
        end
        if (!r) prio = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    initial begin
        rst = 1'b0;
        prio = 1'b0;
        proc_req_val = 1'b0; proc_req_type = 1'b0; proc_req_addr = '0; proc_req_wdata = '0;
        ext_req_val  = 1'b0; ext_req_type  = 1'b0; ext_req_addr  = '0; ext_req_wdata  = '0;
        for (int k = 0; k < 256; k++) ref_mem[k] = 32'h0;

        // reset held with both requesters asserting val
        for (int k = 0; k < 3; k++)
            step(1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h4, 32'h0);

        // contention: PROC writes 0x10, EXT reads 0x10; expect P,E,P,E
        for (int k = 0; k < 4; k++)
            step(1'b1, 1'b1, 1'b1, 32'h10, 32'h1111_1111, 1'b1, 1'b0, 32'h10, 32'h0);
        idle(4);

        // single requester write then read
        step(1'b1, 1'b1, 1'b1, 32'h100, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0, 32'h0);
        step(1'b1, 1'b1, 1'b0, 32'h100, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        idle(4);

        // EXT preload then read with latency checked per instance
        step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h200, 32'h1234_5678);
        idle(1);
        step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h200, 32'h0);
        idle(4);

        // reset mid-flight drops the outstanding read
        step(1'b1, 1'b1, 1'b0, 32'h100, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        idle(4);
        step(1'b1, 1'b1, 1'b0, 32'h200, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        idle(4);

        // cross-requester ordering: EXT write followed by PROC read of same address
        step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h300, 32'hA5A5_A5A5);
        step(1'b1, 1'b1, 1'b0, 32'h300, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        idle(5);

        for (int i = 0; i < 3; i++)
            chk($sformatf("L%0d pending responses", i+1), sb[i].size(), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
